// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath: ALU codes, control-field
// encodings, opcodes, the reset PC and the ALU function.
package mc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU     = 2'b00,
        PCSRC_ALUOUT  = 2'b01,
        PCSRC_JUMP    = 2'b10,
        PCSRC_ALU_ALT = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT     = 2'b00,
        M2R_MDR        = 2'b01,
        M2R_PC         = 2'b10,
        M2R_ALUOUT_ALT = 2'b11
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        DST_RT     = 2'b00,
        DST_RD     = 2'b01,
        DST_RA     = 2'b10,
        DST_RD_ALT = 2'b11
    } reg_dst_e;

    // Unlisted control codes deliberately produce zero rather than a don't-care.
    function automatic logic [31:0] alu_op(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  ctrl);
        logic [31:0] r;
        case (ctrl)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module mc_regfile
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != REG_ZERO)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-edge contents, so a same-edge write is not bypassed.
    assign rd1 = (ra1 == REG_ZERO) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == REG_ZERO) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath steered entirely by the main controller's strobes.
// Optional macro MC_DP_BNE_EN: branch condition is inverted by IR[26] (bne support).
module mc_datapath
    import mc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iord,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic             ir_write,
    input  logic             mem_write,
    input  logic             pc_write,
    input  logic             branch,
    input  logic             reg_write,
    input  logic             ori,
    input  logic [2:0]       alu_control,
    input  logic [1:0]       pc_src,
    input  logic [1:0]       mem_to_reg,
    input  logic [1:0]       reg_dst,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] pc_dbg
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;

    logic [WIDTH-1:0] imm_ext, imm_sh2;
    logic [WIDTH-1:0] src_a, src_b, alu_result;
    logic [WIDTH-1:0] pc_next, wb_data, rd1, rd2;
    logic [4:0]       wb_addr;
    logic             zero_taken, branch_cond;

    mc_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ir_q[25:21]),
        .ra2   (ir_q[20:16]),
        .we    (reg_write),
        .wa    (wb_addr),
        .wd    (wb_data),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // The shifted branch offset always sign-extends, independent of ori.
    always_comb begin
        imm_ext = ori ? {16'b0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
        imm_sh2 = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        src_a   = alu_src_a ? a_q : pc_q;
        src_b   = b_q;
        case (alu_src_b_e'(alu_src_b))
            SRCB_B:       src_b = b_q;
            SRCB_FOUR:    src_b = 32'd4;
            SRCB_IMM:     src_b = imm_ext;
            SRCB_IMM_SH2: src_b = imm_sh2;
            default:      src_b = b_q;
        endcase
        alu_result = alu_op(src_a, src_b, alu_control);
    end

    always_comb begin
        zero_taken = (alu_result == '0);
`ifdef MC_DP_BNE_EN
        branch_cond = zero_taken ^ ir_q[26];
`else
        branch_cond = zero_taken;
`endif
        pc_next = alu_result;
        case (pc_src_e'(pc_src))
            PCSRC_ALU:     pc_next = alu_result;
            PCSRC_ALUOUT:  pc_next = alu_out_q;
            PCSRC_JUMP:    pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            PCSRC_ALU_ALT: pc_next = alu_result;
            default:       pc_next = alu_result;
        endcase
        pc_d = pc_q;
        if (pc_write || (branch && branch_cond)) begin
            pc_d = pc_next;
        end
    end

    always_comb begin
        wb_addr = ir_q[20:16];
        case (reg_dst_e'(reg_dst))
            DST_RT:     wb_addr = ir_q[20:16];
            DST_RD:     wb_addr = ir_q[15:11];
            DST_RA:     wb_addr = REG_RA;
            DST_RD_ALT: wb_addr = ir_q[15:11];
            default:    wb_addr = ir_q[20:16];
        endcase
        wb_data = alu_out_q;
        case (mem_to_reg_e'(mem_to_reg))
            M2R_ALUOUT:     wb_data = alu_out_q;
            M2R_MDR:        wb_data = mdr_q;
            M2R_PC:         wb_data = pc_q;
            M2R_ALUOUT_ALT: wb_data = alu_out_q;
            default:        wb_data = alu_out_q;
        endcase
    end

    // MDR, A, B and ALUOut are free-running staging registers; only PC and IR are gated.
    always_comb begin
        ir_d      = ir_write ? mem_rdata : ir_q;
        mdr_d     = mem_rdata;
        a_d       = rd1;
        b_d       = rd2;
        alu_out_d = alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign mem_addr  = iord ? alu_out_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = mem_write;
    assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: the bench plays controller and memory,
// queues expected outputs as it drives each step and compares them when they appear.
module tb_mc_datapath;
   import mc_pkg::*;

`ifdef MC_DP_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iord, alu_src_a, ir_write, mem_write, pc_write, branch, reg_write, ori;
   logic [1:0]  alu_src_b, pc_src, mem_to_reg, reg_dst;
   logic [2:0]  alu_control;
   logic [5:0]  opcode, funct;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
   logic        mem_we;

   typedef enum int {SEL_PC, SEL_OPCODE, SEL_FUNCT, SEL_ADDR, SEL_WDATA, SEL_WE} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          checksTotal = 0;
   int          checksPassed = 0;
   logic [31:0] pcModel;
   logic [31:0] rfModel [32];

   mc_datapath dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .iord        (iord),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .ir_write    (ir_write),
      .mem_write   (mem_write),
      .pc_write    (pc_write),
      .branch      (branch),
      .reg_write   (reg_write),
      .ori         (ori),
      .alu_control (alu_control),
      .pc_src      (pc_src),
      .mem_to_reg  (mem_to_reg),
      .reg_dst     (reg_dst),
      .opcode      (opcode),
      .funct       (funct),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata),
      .pc_dbg      (pc_dbg)
   );

   // Free-running clock, rising edge every 10 time units.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checksTotal++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         checksPassed++;
      end
   endtask

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         SEL_PC:     return pc_dbg;
         SEL_OPCODE: return {26'b0, opcode};
         SEL_FUNCT:  return {26'b0, funct};
         SEL_ADDR:   return mem_addr;
         SEL_WDATA:  return mem_wdata;
         SEL_WE:     return {31'b0, mem_we};
         default:    return '0;
      endcase
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // Reference ALU, written from the operation table rather than shared with the design.
   function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      if (c == 3'b010) return a + b;
      if (c == 3'b110) return a + ~b + 32'd1;
      if (c == 3'b000) return a & b;
      if (c == 3'b001) return a | b;
      if (c == 3'b111) begin
         if (a[31] != b[31]) return {31'b0, a[31]};
         return (a < b) ? 32'd1 : 32'd0;
      end
      return 32'd0;
   endfunction

   task automatic pushExpect(input string tag, input sel_e sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drainScoreboard();
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checkOutput(e.tag, observe(e.sel), e.val);
      end
   endtask

   // Clock the currently driven controls in, then compare whatever was queued.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      drainScoreboard();
   endtask

   task automatic checkNow();
      #1;
      drainScoreboard();
   endtask

   task automatic idle();
      iord = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; ir_write = 1'b0;
      mem_write = 1'b0; pc_write = 1'b0; branch = 1'b0; reg_write = 1'b0;
      ori = 1'b0; alu_control = 3'b000; pc_src = 2'b00; mem_to_reg = 2'b00; reg_dst = 2'b00;
   endtask

   task automatic doFetch(input logic [31:0] instr);
      idle();
      mem_rdata = instr;
      ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; alu_control = ALU_ADD;
      pushExpect("fetch_addr", SEL_ADDR, pcModel);
      checkNow();
      pcModel = pcModel + 32'd4;
      pushExpect("fetch_pc", SEL_PC, pcModel);
      pushExpect("fetch_opcode", SEL_OPCODE, {26'b0, instr[31:26]});
      pushExpect("fetch_funct", SEL_FUNCT, {26'b0, instr[5:0]});
      applyStimulus();
      idle();
   endtask

   task automatic doDecode();
      idle();
      alu_src_b = 2'b11; alu_control = ALU_ADD;
      applyStimulus();
      idle();
   endtask

   task automatic runOri(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
      logic [31:0] result;
      doFetch({OP_ORI, rs, rt, imm});
      doDecode();
      result = rfModel[rs] | {16'h0, imm};
      alu_src_a = 1'b1; alu_src_b = 2'b10; ori = 1'b1; alu_control = ALU_OR; iord = 1'b1;
      pushExpect("ori_aluout", SEL_ADDR, result);
      applyStimulus();
      idle();
      reg_write = 1'b1;
      pushExpect("wb_no_bypass", SEL_WDATA, rfModel[rt]);
      applyStimulus();
      idle();
      if (rt != 5'd0) rfModel[rt] = result;
      pushExpect("wb_readback", SEL_WDATA, rfModel[rt]);
      applyStimulus();
   endtask

   task automatic loadReg(input logic [4:0] rt, input logic [31:0] value);
      doFetch({OP_LW, 5'd0, rt, 16'h0000});
      doDecode();
      mem_rdata = value;
      applyStimulus();
      reg_write = 1'b1; mem_to_reg = 2'b01;
      applyStimulus();
      idle();
      if (rt != 5'd0) rfModel[rt] = value;
      pushExpect("load_readback", SEL_WDATA, rfModel[rt]);
      applyStimulus();
   endtask

   task automatic runBranch(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] off);
      logic [31:0] target;
      logic        taken;
      doFetch({op, rs, rt, off});
      target = pcModel + (sext16(off) << 2);
      doDecode();
      taken = (rfModel[rs] == rfModel[rt]) ^ (BNE_EN && (op == OP_BNE));
      alu_src_a = 1'b1; alu_control = ALU_SUB; branch = 1'b1; pc_src = 2'b01;
      if (taken) pcModel = target;
      pushExpect("branch_pc", SEL_PC, pcModel);
      applyStimulus();
      idle();
   endtask

   initial begin
      logic [2:0]  codes [6];
      logic [31:0] jalInstr;

      codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, 3'b011};
      for (int i = 0; i < 32; i++) rfModel[i] = 32'd0;
      pcModel = RESET_PC_DEFAULT;

      rst_n = 1'b0;
      idle();
      mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      pushExpect("reset_pc", SEL_PC, RESET_PC_DEFAULT);
      pushExpect("reset_opcode", SEL_OPCODE, 32'd0);
      pushExpect("reset_funct", SEL_FUNCT, 32'd0);
      pushExpect("reset_addr", SEL_ADDR, RESET_PC_DEFAULT);
      pushExpect("reset_wdata", SEL_WDATA, 32'd0);
      checkNow();
      #1;
      rst_n = 1'b1;

      $display("[TB] ori and register writes");
      runOri(5'd8, 5'd0, 16'h00FF);
      runOri(5'd9, 5'd0, 16'h0005);
      runOri(5'd10, 5'd0, 16'h0006);
      loadReg(5'd0, 32'hDEAD_BEEF);

      $display("[TB] branches");
      runBranch(OP_BEQ, 5'd9, 5'd9, 16'h0004);
      runBranch(OP_BEQ, 5'd9, 5'd10, 16'h0004);
      runBranch(OP_BNE, 5'd9, 5'd10, 16'h0004);
      runBranch(OP_BNE, 5'd9, 5'd9, 16'h0004);
      runBranch(OP_BEQ, 5'd10, 5'd10, 16'hFFFD);

      $display("[TB] immediate extension");
      doFetch({OP_ORI, 5'd0, 5'd8, 16'h8001});
      doDecode();
      alu_src_a = 1'b1; alu_src_b = 2'b10; ori = 1'b1; alu_control = ALU_OR; iord = 1'b1;
      pushExpect("imm_zext", SEL_ADDR, 32'h0000_8001);
      applyStimulus();
      ori = 1'b0; alu_control = ALU_ADD;
      pushExpect("imm_sext", SEL_ADDR, 32'hFFFF_8001);
      applyStimulus();
      idle();

      $display("[TB] store");
      loadReg(5'd11, 32'h1234_5678);
      loadReg(5'd12, 32'h1001_0000);
      doFetch({OP_SW, 5'd12, 5'd11, 16'h0000});
      doDecode();
      alu_src_a = 1'b1; alu_src_b = 2'b10; alu_control = ALU_ADD;
      applyStimulus();
      idle();
      iord = 1'b1; mem_write = 1'b1;
      pushExpect("store_addr", SEL_ADDR, 32'h1001_0000);
      pushExpect("store_wdata", SEL_WDATA, 32'h1234_5678);
      pushExpect("store_we", SEL_WE, 32'd1);
      checkNow();
      applyStimulus();
      idle();
      pushExpect("store_we_low", SEL_WE, 32'd0);
      checkNow();

      $display("[TB] ALU sweep");
      loadReg(5'd13, 32'hFFFF_FFF0);
      doFetch({OP_RTYPE, 5'd13, 5'd9, 5'd14, 5'd0, 6'h2A});
      doDecode();
      for (int i = 0; i < 6; i++) begin
         alu_src_a = 1'b1; alu_src_b = 2'b00; alu_control = codes[i]; iord = 1'b1;
         pushExpect($sformatf("alu_code_%0d", codes[i]), SEL_ADDR, aluModel(rfModel[13], rfModel[9], codes[i]));
         applyStimulus();
      end
      alu_src_b = 2'b01; alu_control = ALU_ADD;
      pushExpect("alu_plus4", SEL_ADDR, aluModel(rfModel[13], 32'd4, ALU_ADD));
      applyStimulus();
      idle();

      $display("[TB] jal");
      jalInstr = {OP_JAL, 26'h010_0040};
      doFetch(jalInstr);
      pc_write = 1'b1; pc_src = 2'b10; reg_write = 1'b1; reg_dst = 2'b10; mem_to_reg = 2'b10;
      rfModel[31] = pcModel;
      pcModel = {pcModel[31:28], jalInstr[25:0], 2'b00};
      pushExpect("jal_pc", SEL_PC, pcModel);
      applyStimulus();
      idle();
      doFetch({OP_RTYPE, 5'd0, 5'd31, 5'd0, 5'd0, 6'h20});
      pushExpect("jal_link", SEL_WDATA, rfModel[31]);
      doDecode();

      $display("[TB] reset mid-instruction");
      mem_rdata = 32'hAC0B_1234;
      ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; alu_control = ALU_ADD; mem_write = 1'b1;
      #2;
      rst_n = 1'b0;
      pushExpect("midreset_pc", SEL_PC, RESET_PC_DEFAULT);
      pushExpect("midreset_opcode", SEL_OPCODE, 32'd0);
      pushExpect("midreset_funct", SEL_FUNCT, 32'd0);
      pushExpect("midreset_addr", SEL_ADDR, RESET_PC_DEFAULT);
      pushExpect("midreset_wdata", SEL_WDATA, 32'd0);
      pushExpect("midreset_we", SEL_WE, 32'd1);
      checkNow();
      pushExpect("held_reset_pc", SEL_PC, RESET_PC_DEFAULT);
      applyStimulus();
      idle();
      #2;
      rst_n = 1'b1;
      pushExpect("post_reset_pc", SEL_PC, RESET_PC_DEFAULT);
      applyStimulus();

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
